count16_timestamp_capture: RTL



---
 rtl/count16_ts_pkg.sv | 13 +
 rtl/ts_sync_fifo.sv | 67 ++++++
 rtl/count16_timestamp_capture.sv | 66 ++++++
 3 files changed

// File: rtl/count16_ts_pkg.sv
// Shared widths and types for the count16 timestamp capture block.
package count16_ts_pkg;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned EXT_W_DEF = 16;

   function automatic int unsigned ts_width(input int unsigned ext_w);
      return ext_w + CNT_W;
   endfunction

   localparam int unsigned TS_W = ts_width(EXT_W_DEF);

   typedef logic [TS_W-1:0] ts_t;
endpackage

// File: rtl/ts_sync_fifo.sv
// Synchronous FIFO with a registered head entry; head reads zero when empty.
module ts_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic [WIDTH-1:0]           head_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [PTR_W-1:0] rd_next;

   assign rd_next = rd_ptr_q + PTR_W'(1);

   // Head tracks the oldest entry; the writer slot never aliases rd_next while level>=2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LVL_W'(push_i) - LVL_W'(pop_i);
      head_d   = head_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_next;
      if (level_d == '0) begin
         head_d = '0;
      end else if (level_q == '0) begin
         head_d = din_i;
      end else if (pop_i) begin
         head_d = (level_q == LVL_W'(1)) ? din_i : mem_q[rd_next];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = head_q;
endmodule

// File: rtl/count16_timestamp_capture.sv
// Extends the upstream 16-bit count into a wrap-safe timestamp and queues
// snapshots on capture for a valid/ready consumer.
module count16_timestamp_capture
   import count16_ts_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned EXT_WIDTH = 16
) (
   input  logic                            clock0,
   input  logic                            reset,
   input  logic [CNT_W-1:0]                count_in,
   input  logic                            capture,
   output logic                            ts_valid,
   input  logic                            ts_ready,
   output logic [ts_width(EXT_WIDTH)-1:0]  ts_data,
   output logic [$clog2(DEPTH+1)-1:0]      level,
   output logic                            overflow
);
   localparam int unsigned TW = ts_width(EXT_WIDTH);

   logic [CNT_W-1:0]     count_q;
   logic [EXT_WIDTH-1:0] ext_q, ext_d;
   logic                 overflow_q, overflow_d;
   logic                 wrap, push, pop, full, empty;
   logic [TW-1:0]        snap;

   // A drop in the count means the upstream counter rolled over since last cycle.
   always_comb begin
      wrap       = (count_in < count_q);
      ext_d      = ext_q + EXT_WIDTH'(wrap);
      snap       = {ext_d, count_in};
      pop        = !empty && ts_ready;
      push       = capture && (!full || pop);
      overflow_d = overflow_q || (capture && full && !pop);
   end

   always_ff @(posedge clock0) begin
      if (reset) begin
         count_q    <= '0;
         ext_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_in;
         ext_q      <= ext_d;
         overflow_q <= overflow_d;
      end
   end

   ts_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TW)
   ) u_fifo (
      .clk_i   (clock0),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (snap),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level),
      .head_o  (ts_data)
   );

   assign ts_valid = !empty;
   assign overflow = overflow_q;
endmodule
